// File: rtl/adma_chn_desc_queue.sv
// Per-channel DMA descriptor queue.
// A circular buffer of descriptors, indexed by transfer ID. A small issue FSM
// offers the descriptor at rd_ptr to the transfer engine and waits for its
// completion pulse. Completion status is kept per slot. Sticky interrupt
// status bits are set on push (queued) and on completion.
//
// Handshakes: a transfer happens on a rising aclk edge where vld and rdy are
// both 1. A producer holding vld keeps its payload stable until that edge.
// desc_wr_rdy_o depends only on the fill count. desc_rd_vld_o depends only on
// FSM state. While it is high the issued payload is stable until the edge.
module adma_chn_desc_queue #(
  parameter int DMA_DESC_DEPTH = 4,
  parameter int SRC_ADDR_W     = 32,
  parameter int DST_ADDR_W     = 32,
  parameter int DMA_LENGTH_W   = 16,
  parameter int DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      chn_ctrl_en,
  input  logic                      chn_xfer_cyclic,
  input  logic                      chn_irq_msk_irq_com,
  input  logic                      chn_irq_msk_irq_qed,
  input  logic [1:0]                irq_clr_i,
  input  logic                      desc_wr_vld_i,
  output logic                      desc_wr_rdy_o,
  input  logic [SRC_ADDR_W-1:0]     desc_src_addr_i,
  input  logic [DST_ADDR_W-1:0]     desc_dst_addr_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_xfer_xlen_i,
  input  logic [DMA_LENGTH_W-1:0]   desc_xfer_ylen_i,
  input  logic [SRC_ADDR_W-1:0]     desc_src_strd_i,
  input  logic [DST_ADDR_W-1:0]     desc_dst_strd_i,
  output logic                      desc_rd_vld_o,
  input  logic                      desc_rd_rdy_i,
  output logic [DMA_XFER_ID_W-1:0]  desc_rd_id_o,
  output logic [SRC_ADDR_W-1:0]     desc_src_addr_o,
  output logic [DST_ADDR_W-1:0]     desc_dst_addr_o,
  output logic [DMA_LENGTH_W-1:0]   desc_xfer_xlen_o,
  output logic [DMA_LENGTH_W-1:0]   desc_xfer_ylen_o,
  output logic [SRC_ADDR_W-1:0]     desc_src_strd_o,
  output logic [DST_ADDR_W-1:0]     desc_dst_strd_o,
  input  logic                      xfer_cmpl_i,
  output logic [DMA_XFER_ID_W-1:0]  xfer_id,
  output logic [DMA_DESC_DEPTH-1:0] xfer_done,
  output logic [DMA_XFER_ID_W-1:0]  active_xfer_id,
  output logic [DMA_LENGTH_W-1:0]   active_xfer_len,
  output logic                      chn_irq_src_irq_com,
  output logic                      chn_irq_src_irq_qed,
  output logic [1:0]                fsm_state
);

  localparam int CNT_W = DMA_XFER_ID_W + 1;
  localparam logic [CNT_W-1:0]         DEPTH_CNT = CNT_W'(DMA_DESC_DEPTH);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [DMA_XFER_ID_W-1:0] ID_ONE    = DMA_XFER_ID_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Descriptor storage; slot index is the transfer ID. No reset on purpose.
  logic [SRC_ADDR_W-1:0]   src_mem  [DMA_DESC_DEPTH];
  logic [DST_ADDR_W-1:0]   dst_mem  [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] xlen_mem [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] ylen_mem [DMA_DESC_DEPTH];
  logic [SRC_ADDR_W-1:0]   sstr_mem [DMA_DESC_DEPTH];
  logic [DST_ADDR_W-1:0]   dstr_mem [DMA_DESC_DEPTH];

  logic [DMA_XFER_ID_W-1:0] wr_ptr;
  logic [DMA_XFER_ID_W-1:0] rd_ptr;
  logic [DMA_XFER_ID_W-1:0] rd_ptr_inc;
  logic [DMA_XFER_ID_W-1:0] rd_ptr_nxt;
  logic [DMA_XFER_ID_W-1:0] lap_start;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_nxt;
  state_t                   state;
  state_t                   state_nxt;
  logic                     push;
  logic                     issue_hs;
  logic                     pop;

  assign desc_wr_rdy_o = (count < DEPTH_CNT);
  assign push          = desc_wr_vld_i & desc_wr_rdy_o;
  assign desc_rd_vld_o = (state == ST_ISSUE);
  assign issue_hs      = desc_rd_vld_o & desc_rd_rdy_i;
  assign pop           = xfer_cmpl_i & (state == ST_BUSY);

  // Oldest queued slot. In cyclic mode the read pointer rewinds here after a lap.
  assign lap_start  = wr_ptr - count[DMA_XFER_ID_W-1:0];
  assign rd_ptr_inc = rd_ptr + ID_ONE;

  // Next fill count. A cyclic completion keeps its slot, so it does not decrement.
  always_comb begin
    count_nxt = count;
    case ({push, pop & ~chn_xfer_cyclic})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Next read pointer. A cyclic lap wraps back to the oldest slot after the newest
  // one. A push in the same cycle extends the lap to the new slot instead.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (pop) begin
      if (chn_xfer_cyclic && !push && (rd_ptr_inc == wr_ptr)) begin
        rd_ptr_nxt = lap_start;
      end else begin
        rd_ptr_nxt = rd_ptr_inc;
      end
    end
  end

  // Pointers, count and FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ID_ONE;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      state  <= state_nxt;
    end
  end

  // Issue FSM. The enable only gates entry into ISSUE. It never withdraws an
  // offer and never aborts a transfer. Entry uses the post-update count, so
  // an offer appears the cycle after a push or a completion.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (chn_ctrl_en && (count_nxt != '0)) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_hs) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (pop) begin
          state_nxt = (chn_ctrl_en && (count_nxt != '0)) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write the pushed payload into the slot named by wr_ptr.
  always_ff @(posedge aclk) begin
    if (push) begin
      src_mem[wr_ptr]  <= desc_src_addr_i;
      dst_mem[wr_ptr]  <= desc_dst_addr_i;
      xlen_mem[wr_ptr] <= desc_xfer_xlen_i;
      ylen_mem[wr_ptr] <= desc_xfer_ylen_i;
      sstr_mem[wr_ptr] <= desc_src_strd_i;
      dstr_mem[wr_ptr] <= desc_dst_strd_i;
    end
  end

  // Per-slot completion flags. A push clears its slot. A completion sets the
  // active slot. These two are never the same slot in one cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xfer_done <= '0;
    end else begin
      if (push) begin
        xfer_done[wr_ptr] <= 1'b0;
      end
      if (pop) begin
        xfer_done[rd_ptr] <= 1'b1;
      end
    end
  end

  // Sticky interrupt status. A set wins over a clear in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chn_irq_src_irq_com <= 1'b0;
      chn_irq_src_irq_qed <= 1'b0;
    end else begin
      if (pop && chn_irq_msk_irq_com) begin
        chn_irq_src_irq_com <= 1'b1;
      end else if (irq_clr_i[0]) begin
        chn_irq_src_irq_com <= 1'b0;
      end
      if (push && chn_irq_msk_irq_qed) begin
        chn_irq_src_irq_qed <= 1'b1;
      end else if (irq_clr_i[1]) begin
        chn_irq_src_irq_qed <= 1'b0;
      end
    end
  end

  assign desc_rd_id_o     = rd_ptr;
  assign desc_src_addr_o  = src_mem[rd_ptr];
  assign desc_dst_addr_o  = dst_mem[rd_ptr];
  assign desc_xfer_xlen_o = xlen_mem[rd_ptr];
  assign desc_xfer_ylen_o = ylen_mem[rd_ptr];
  assign desc_src_strd_o  = sstr_mem[rd_ptr];
  assign desc_dst_strd_o  = dstr_mem[rd_ptr];

  assign xfer_id          = wr_ptr;
  assign active_xfer_id   = rd_ptr;
  assign active_xfer_len  = (state != ST_IDLE) ? xlen_mem[rd_ptr] : '0;
  assign fsm_state        = state;

endmodule

// File: tb/tb_adma_chn_desc_queue.sv
// Testbench for adma_chn_desc_queue: directed scenarios with literal
// expectations, then randomized phases checked against a queue-based model.
module tb_adma_chn_desc_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic        aclk;
  logic        aresetn;
  logic        chn_ctrl_en;
  logic        chn_xfer_cyclic;
  logic        chn_irq_msk_irq_com;
  logic        chn_irq_msk_irq_qed;
  logic [1:0]  irq_clr_i;
  logic        desc_wr_vld_i;
  logic        desc_wr_rdy_o;
  logic [31:0] desc_src_addr_i;
  logic [31:0] desc_dst_addr_i;
  logic [15:0] desc_xfer_xlen_i;
  logic [15:0] desc_xfer_ylen_i;
  logic [31:0] desc_src_strd_i;
  logic [31:0] desc_dst_strd_i;
  logic        desc_rd_vld_o;
  logic        desc_rd_rdy_i;
  logic [IDW-1:0] desc_rd_id_o;
  logic [31:0] desc_src_addr_o;
  logic [31:0] desc_dst_addr_o;
  logic [15:0] desc_xfer_xlen_o;
  logic [15:0] desc_xfer_ylen_o;
  logic [31:0] desc_src_strd_o;
  logic [31:0] desc_dst_strd_o;
  logic        xfer_cmpl_i;
  logic [IDW-1:0]   xfer_id;
  logic [DEPTH-1:0] xfer_done;
  logic [IDW-1:0]   active_xfer_id;
  logic [15:0] active_xfer_len;
  logic        chn_irq_src_irq_com;
  logic        chn_irq_src_irq_qed;
  logic [1:0]  fsm_state;

  adma_chn_desc_queue #(.DMA_DESC_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .chn_ctrl_en(chn_ctrl_en), .chn_xfer_cyclic(chn_xfer_cyclic),
    .chn_irq_msk_irq_com(chn_irq_msk_irq_com), .chn_irq_msk_irq_qed(chn_irq_msk_irq_qed),
    .irq_clr_i(irq_clr_i),
    .desc_wr_vld_i(desc_wr_vld_i), .desc_wr_rdy_o(desc_wr_rdy_o),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
    .desc_xfer_xlen_i(desc_xfer_xlen_i), .desc_xfer_ylen_i(desc_xfer_ylen_i),
    .desc_src_strd_i(desc_src_strd_i), .desc_dst_strd_i(desc_dst_strd_i),
    .desc_rd_vld_o(desc_rd_vld_o), .desc_rd_rdy_i(desc_rd_rdy_i),
    .desc_rd_id_o(desc_rd_id_o),
    .desc_src_addr_o(desc_src_addr_o), .desc_dst_addr_o(desc_dst_addr_o),
    .desc_xfer_xlen_o(desc_xfer_xlen_o), .desc_xfer_ylen_o(desc_xfer_ylen_o),
    .desc_src_strd_o(desc_src_strd_o), .desc_dst_strd_o(desc_dst_strd_o),
    .xfer_cmpl_i(xfer_cmpl_i),
    .xfer_id(xfer_id), .xfer_done(xfer_done),
    .active_xfer_id(active_xfer_id), .active_xfer_len(active_xfer_len),
    .chn_irq_src_irq_com(chn_irq_src_irq_com), .chn_irq_src_irq_qed(chn_irq_src_irq_qed),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] xlen;
    logic [15:0] ylen;
    logic [31:0] sstr;
    logic [31:0] dstr;
    int          id;
  } desc_t;

  desc_t          mq[$];      // queued descriptors, oldest first
  int             mpos;       // index in mq of the descriptor being issued
  int             mst;        // 0 idle, 1 offering, 2 engine busy
  int             mnext_id;
  logic [DEPTH-1:0] mdone;
  logic           mcom;
  logic           mqed;
  logic [IDW-1:0] exp_q[$];   // expected issue order for the drain scenario

  int checks;
  int errors;

  task automatic model_reset();
    mq.delete();
    mpos = 0; mst = 0; mnext_id = 0;
    mdone = '0; mcom = 1'b0; mqed = 1'b0;
  endtask

  task automatic model_step();
    desc_t d;
    bit push, hs, cmpl;
    push = desc_wr_vld_i && (mq.size() < DEPTH);
    hs   = (mst == 1) && desc_rd_rdy_i;
    cmpl = (mst == 2) && xfer_cmpl_i;
    if (cmpl) mdone[mq[mpos].id] = 1'b1;
    if (push) begin
      d.src = desc_src_addr_i; d.dst = desc_dst_addr_i;
      d.xlen = desc_xfer_xlen_i; d.ylen = desc_xfer_ylen_i;
      d.sstr = desc_src_strd_i; d.dstr = desc_dst_strd_i;
      d.id = mnext_id;
      mq.push_back(d);
      mdone[mnext_id] = 1'b0;
      mnext_id = (mnext_id + 1) % DEPTH;
    end
    if (cmpl) begin
      if (chn_xfer_cyclic) begin
        mpos++;
        if (mpos >= mq.size()) mpos = 0;
      end else begin
        void'(mq.pop_front());
      end
    end
    mqed = (push && chn_irq_msk_irq_qed) ? 1'b1 : (irq_clr_i[1] ? 1'b0 : mqed);
    mcom = (cmpl && chn_irq_msk_irq_com) ? 1'b1 : (irq_clr_i[0] ? 1'b0 : mcom);
    case (mst)
      0: if (chn_ctrl_en && mq.size() != 0) mst = 1;
      1: if (hs) mst = 2;
      default: if (cmpl) mst = (chn_ctrl_en && mq.size() != 0) ? 1 : 0;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t state=%0d)", name, act, exp, $time, fsm_state);
    end
  endtask

  task automatic compare_all();
    check("wr_rdy", desc_wr_rdy_o, mq.size() < DEPTH);
    check("rd_vld", desc_rd_vld_o, mst == 1);
    if (mst == 1) begin
      check("rd_id",   desc_rd_id_o,     mq[mpos].id);
      check("rd_src",  desc_src_addr_o,  mq[mpos].src);
      check("rd_dst",  desc_dst_addr_o,  mq[mpos].dst);
      check("rd_xlen", desc_xfer_xlen_o, mq[mpos].xlen);
      check("rd_ylen", desc_xfer_ylen_o, mq[mpos].ylen);
      check("rd_sstr", desc_src_strd_o,  mq[mpos].sstr);
      check("rd_dstr", desc_dst_strd_o,  mq[mpos].dstr);
    end
    check("xfer_id",   xfer_id,   mnext_id);
    check("xfer_done", xfer_done, mdone);
    check("active_id", active_xfer_id, (mq.size() != 0) ? mq[mpos].id : mnext_id);
    check("active_len", active_xfer_len, (mst != 0) ? mq[mpos].xlen : 16'd0);
    check("irq_com", chn_irq_src_irq_com, mcom);
    check("irq_qed", chn_irq_src_irq_qed, mqed);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge aclk);
    if (!aresetn) model_reset();
    else model_step();
    @(negedge aclk);
    compare_all();
  endtask

  task automatic rand_payload();
    desc_src_addr_i  = $urandom;
    desc_dst_addr_i  = $urandom;
    desc_xfer_xlen_i = 16'($urandom_range(1, 65535));
    desc_xfer_ylen_i = 16'($urandom_range(0, 65535));
    desc_src_strd_i  = $urandom;
    desc_dst_strd_i  = $urandom;
  endtask

  task automatic clear_inputs();
    chn_ctrl_en = 1'b0; irq_clr_i = 2'b00;
    desc_wr_vld_i = 1'b0; desc_rd_rdy_i = 1'b0; xfer_cmpl_i = 1'b0;
    rand_payload();
  endtask

  task automatic do_reset(input logic cyclic);
    aresetn = 1'b0;
    clear_inputs();
    chn_xfer_cyclic = cyclic;
    cyc();
    cyc();
    aresetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0;
    aresetn = 1'b0;
    chn_xfer_cyclic = 1'b0;
    chn_irq_msk_irq_com = 1'b0; chn_irq_msk_irq_qed = 1'b0;
    clear_inputs();
    model_reset();
    cyc();
    cyc();
    check("rst_wr_rdy", desc_wr_rdy_o, 1'b1);
    check("rst_rd_vld", desc_rd_vld_o, 1'b0);
    check("rst_done",   xfer_done, 4'b0000);
    check("rst_len",    active_xfer_len, 16'd0);
    aresetn = 1'b1;

    // Single descriptor round trip.
    chn_ctrl_en = 1'b1;
    desc_wr_vld_i = 1'b1; rand_payload();
    desc_src_addr_i = 32'h1000; desc_xfer_xlen_i = 16'd8;
    cyc();
    desc_wr_vld_i = 1'b0;
    check("t1_vld", desc_rd_vld_o, 1'b1);
    check("t1_id",  desc_rd_id_o, 2'd0);
    check("t1_src", desc_src_addr_o, 32'h1000);
    check("t1_len", active_xfer_len, 16'd8);
    desc_rd_rdy_i = 1'b1;
    cyc();
    desc_rd_rdy_i = 1'b0;
    check("t1_busy_vld", desc_rd_vld_o, 1'b0);
    check("t1_busy_len", active_xfer_len, 16'd8);
    xfer_cmpl_i = 1'b1;
    cyc();
    xfer_cmpl_i = 1'b0;
    check("t1_done", xfer_done, 4'b0001);
    check("t1_idle_len", active_xfer_len, 16'd0);

    // Fill with the channel disabled: the fifth push is refused.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      desc_wr_vld_i = 1'b1; rand_payload();
      check("t2_wr_rdy", desc_wr_rdy_o, (i < 4) ? 1'b1 : 1'b0);
      cyc();
    end
    desc_wr_vld_i = 1'b0;
    check("t2_xfer_id", xfer_id, 2'd0);
    check("t2_vld", desc_rd_vld_o, 1'b0);

    // Drain the full queue in order.
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    chn_ctrl_en = 1'b1; desc_rd_rdy_i = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("t3_vld", desc_rd_vld_o, 1'b1);
      check("t3_id", desc_rd_id_o, exp_q.pop_front());
      cyc();
      xfer_cmpl_i = 1'b1;
      cyc();
      xfer_cmpl_i = 1'b0;
    end
    desc_rd_rdy_i = 1'b0;
    check("t3_done", xfer_done, 4'b1111);
    check("t3_idle", desc_rd_vld_o, 1'b0);
    desc_wr_vld_i = 1'b1; rand_payload();
    cyc();
    desc_wr_vld_i = 1'b0;
    check("t3_done_clr", xfer_done, 4'b1110);
    check("t3_reissue_id", desc_rd_id_o, 2'd0);

    // Cyclic mode with two descriptors.
    do_reset(1'b1);
    chn_ctrl_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      desc_wr_vld_i = 1'b1; rand_payload();
      cyc();
    end
    desc_wr_vld_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t4_vld", desc_rd_vld_o, 1'b1);
      check("t4_id", desc_rd_id_o, (i % 2 == 0) ? 2'd0 : 2'd1);
      check("t4_wr_rdy", desc_wr_rdy_o, 1'b1);
      desc_rd_rdy_i = 1'b1;
      cyc();
      desc_rd_rdy_i = 1'b0; xfer_cmpl_i = 1'b1;
      cyc();
      xfer_cmpl_i = 1'b0;
    end

    // Interrupt set/clear priority.
    do_reset(1'b0);
    chn_irq_msk_irq_com = 1'b1; chn_irq_msk_irq_qed = 1'b1;
    chn_ctrl_en = 1'b1;
    desc_wr_vld_i = 1'b1; rand_payload();
    cyc();
    desc_wr_vld_i = 1'b0;
    check("t5_qed_set", chn_irq_src_irq_qed, 1'b1);
    irq_clr_i = 2'b10;
    cyc();
    irq_clr_i = 2'b00;
    check("t5_qed_clr", chn_irq_src_irq_qed, 1'b0);
    desc_rd_rdy_i = 1'b1;
    cyc();
    desc_rd_rdy_i = 1'b0; xfer_cmpl_i = 1'b1; irq_clr_i = 2'b11;
    cyc();
    xfer_cmpl_i = 1'b0;
    check("t5_com_set_wins", chn_irq_src_irq_com, 1'b1);
    irq_clr_i = 2'b01;
    cyc();
    irq_clr_i = 2'b00;
    check("t5_com_clr", chn_irq_src_irq_com, 1'b0);

    // Asynchronous reset while busy with three queued.
    do_reset(1'b0);
    chn_ctrl_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      desc_wr_vld_i = 1'b1; rand_payload();
      cyc();
    end
    desc_wr_vld_i = 1'b0; desc_rd_rdy_i = 1'b1;
    cyc();
    desc_rd_rdy_i = 1'b0;
    aresetn = 1'b0;
    #1;
    check("t6_vld", desc_rd_vld_o, 1'b0);
    check("t6_wr_rdy", desc_wr_rdy_o, 1'b1);
    check("t6_done", xfer_done, 4'b0000);
    check("t6_qed", chn_irq_src_irq_qed, 1'b0);
    check("t6_len", active_xfer_len, 16'd0);
    check("t6_xfer_id", xfer_id, 2'd0);
    check("t6_active_id", active_xfer_id, 2'd0);
    model_reset();
    cyc();
    aresetn = 1'b1; xfer_cmpl_i = 1'b1;
    cyc();
    xfer_cmpl_i = 1'b0;
    check("t6_cmpl_ignored", xfer_done, 4'b0000);
    desc_wr_vld_i = 1'b1; rand_payload();
    cyc();
    desc_wr_vld_i = 1'b0;
    check("t6_new_id", desc_rd_id_o, 2'd0);
    check("t6_new_vld", desc_rd_vld_o, 1'b1);

    // Randomized phases against the model.
    for (int p = 0; p < 6; p++) begin
      do_reset((p % 3) == 2);
      chn_irq_msk_irq_com = ($urandom_range(0, 1) == 1);
      chn_irq_msk_irq_qed = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 500; c++) begin
        chn_ctrl_en   = ($urandom_range(0, 9) != 0);
        desc_wr_vld_i = ($urandom_range(0, 9) < 4);
        rand_payload();
        desc_rd_rdy_i = ($urandom_range(0, 1) == 1);
        xfer_cmpl_i   = ($urandom_range(0, 3) == 0);
        irq_clr_i     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
